// File: rtl/ifmap_row_writer.sv
// Stages one ifmap row from a host and streams it, or a zero flush row, into
// the CNN IFmap buffer over a write_enable/ready handshake with row-boundary flags.
module ifmap_row_writer #(
  parameter int DATA_WIDTH         = 16,
  parameter int IFMAP_BUFFER_WIDTH = 18,
  parameter int ROW_DEPTH          = 16,
  parameter int FILTER_SIZE_WIDTH  = 5,
  parameter int COUNT_WIDTH        = $clog2(ROW_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ld_valid,
  input  logic [DATA_WIDTH-1:0]         ld_data,
  output logic                          ld_ready,
  input  logic                          start_row,
  input  logic                          flush,
  input  logic [FILTER_SIZE_WIDTH-1:0]  filter_size,
  output logic [IFMAP_BUFFER_WIDTH-1:0] IFmap_buffer_in,
  output logic                          IFmap_buffer_write_enable,
  input  logic                          IFmap_buffer_ready,
  output logic                          busy,
  output logic                          done,
  output logic [COUNT_WIDTH-1:0]        staged_count
);

  localparam int IDX_W = (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic logic [IFMAP_BUFFER_WIDTH-1:0] pack_word(
    input logic                  first,
    input logic                  last,
    input logic [DATA_WIDTH-1:0] data
  );
    pack_word = IFMAP_BUFFER_WIDTH'({first, last, data});
  endfunction

  state_t                         state, state_nxt;
  logic [COUNT_WIDTH-1:0]         count, count_nxt;
  logic [COUNT_WIDTH-1:0]         ptr, ptr_nxt;
  logic [FILTER_SIZE_WIDTH-1:0]   fidx, fidx_nxt;
  logic [FILTER_SIZE_WIDTH-1:0]   len, len_nxt;
  logic                           we, we_nxt;
  logic [IFMAP_BUFFER_WIDTH-1:0]  word, word_nxt;
  logic                           done_q, done_nxt;

  logic [DATA_WIDTH-1:0]          mem [ROW_DEPTH];

  logic                           load_fire;
  logic                           xfer;
  logic [COUNT_WIDTH-1:0]         ptr_inc;
  logic [COUNT_WIDTH-1:0]         last_ptr;
  logic [FILTER_SIZE_WIDTH-1:0]   fidx_inc;
  logic [FILTER_SIZE_WIDTH-1:0]   last_fidx;

  assign ld_ready   = (state == IDLE) && (count < COUNT_WIDTH'(ROW_DEPTH));
  assign load_fire  = ld_valid && ld_ready;
  assign xfer       = we && IFmap_buffer_ready;
  assign ptr_inc    = ptr + COUNT_WIDTH'(1);
  assign last_ptr   = count - COUNT_WIDTH'(1);
  assign fidx_inc   = fidx + FILTER_SIZE_WIDTH'(1);
  assign last_fidx  = len - FILTER_SIZE_WIDTH'(1);

  assign IFmap_buffer_in           = word;
  assign IFmap_buffer_write_enable = we;
  assign busy                      = (state != IDLE);
  assign done                      = done_q;
  assign staged_count              = count;

  // Staging RAM holds payload only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[count[IDX_W-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      ptr    <= '0;
      fidx   <= '0;
      len    <= '0;
      we     <= 1'b0;
      word   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      ptr    <= ptr_nxt;
      fidx   <= fidx_nxt;
      len    <= len_nxt;
      we     <= we_nxt;
      word   <= word_nxt;
      done_q <= done_nxt;
    end
  end

  // The next word is registered at the accepting edge, so a stalled word
  // simply holds and ready never reaches write_enable combinationally.
  always_comb begin
    state_nxt = state;
    count_nxt = count + COUNT_WIDTH'(load_fire);
    ptr_nxt   = ptr;
    fidx_nxt  = fidx;
    len_nxt   = len;
    we_nxt    = we;
    word_nxt  = word;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start_row) begin
          if (count != '0) begin
            state_nxt = SEND;
            ptr_nxt   = '0;
            we_nxt    = 1'b1;
            word_nxt  = pack_word(1'b1, count_nxt == COUNT_WIDTH'(1), mem[IDX_W'(0)]);
          end else begin
            done_nxt  = 1'b1;
          end
        end else if (flush) begin
          if (filter_size != '0) begin
            state_nxt = FLUSH;
            len_nxt   = filter_size;
            fidx_nxt  = '0;
            we_nxt    = 1'b1;
            word_nxt  = pack_word(1'b1, filter_size == FILTER_SIZE_WIDTH'(1), '0);
          end else begin
            done_nxt  = 1'b1;
          end
        end
      end

      SEND: begin
        if (xfer) begin
          if (ptr == last_ptr) begin
            state_nxt = IDLE;
            count_nxt = '0;
            we_nxt    = 1'b0;
            word_nxt  = '0;
            done_nxt  = 1'b1;
          end else begin
            ptr_nxt   = ptr_inc;
            word_nxt  = pack_word(1'b0, ptr_inc == last_ptr, mem[ptr_inc[IDX_W-1:0]]);
          end
        end
      end

      FLUSH: begin
        if (xfer) begin
          if (fidx == last_fidx) begin
            state_nxt = IDLE;
            we_nxt    = 1'b0;
            word_nxt  = '0;
            done_nxt  = 1'b1;
          end else begin
            fidx_nxt  = fidx_inc;
            word_nxt  = pack_word(1'b0, fidx_inc == last_fidx, '0);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        we_nxt    = 1'b0;
        word_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ifmap_row_writer.sv
// Self-checking bench for ifmap_row_writer: directed rows/flushes plus random
// traffic, scored against expected word streams built from the row contents.
module tb_ifmap_row_writer;
  localparam int DW = 16;
  localparam int BW = 18;
  localparam int RD = 16;
  localparam int FW = 5;
  localparam int CW = $clog2(RD + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          start_row;
  logic          flush;
  logic [FW-1:0] filter_size;
  logic [BW-1:0] buf_in;
  logic          we;
  logic          ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] staged_count;

  ifmap_row_writer #(
    .DATA_WIDTH(DW), .IFMAP_BUFFER_WIDTH(BW), .ROW_DEPTH(RD),
    .FILTER_SIZE_WIDTH(FW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .start_row(start_row), .flush(flush), .filter_size(filter_size),
    .IFmap_buffer_in(buf_in), .IFmap_buffer_write_enable(we),
    .IFmap_buffer_ready(ready), .busy(busy), .done(done),
    .staged_count(staged_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] stage_q[$];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got[$];
  int done_cnt, done_cycle, first_we, stab_err;
  logic [6:0] ready_pat = 7'b1101001;

  // Reference: a row of n words is index-tagged start (first) / end (last).
  task automatic expect_row();
    exp_q.delete();
    for (int i = 0; i < stage_q.size(); i++)
      exp_q.push_back({(i == 0), (i == stage_q.size() - 1), stage_q[i]});
  endtask

  task automatic expect_flush(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == 0), (i == n - 1), {DW{1'b0}}});
  endtask

  task automatic load_word(input logic [DW-1:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    if (stage_q.size() < RD) stage_q.push_back(d);
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic f, input logic [FW-1:0] fs);
    start_row   = s;
    flush       = f;
    filter_size = fs;
    @(posedge clk); #1;
    start_row = 1'b0;
    flush     = 1'b0;
  endtask

  // rmode: 0 ready high, 1 fixed toggle pattern, 2 random (high in second half).
  // poke: cycle index at which start_row and flush are pulsed together (-1 none).
  task automatic collect(input int ncyc, input int rmode, input int poke);
    logic          hold;
    logic [BW-1:0] held;
    logic          r;
    got.delete();
    done_cnt = 0; done_cycle = -1; first_we = -1; stab_err = 0; hold = 1'b0; held = '0;
    for (int i = 0; i < ncyc; i++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = i;
      end
      if (we === 1'b1 && first_we < 0) first_we = i;
      if (hold && (we !== 1'b1 || buf_in !== held)) stab_err++;
      case (rmode)
        0:       r = 1'b1;
        1:       r = (i < 7) ? ready_pat[i] : 1'b1;
        default: r = (i >= ncyc / 2) ? 1'b1 : ($urandom_range(0, 9) < 7);
      endcase
      ready       = r;
      start_row   = (i == poke);
      flush       = (i == poke);
      filter_size = 5'd3;
      hold        = 1'b0;
      if (we === 1'b1) begin
        if (r) got.push_back(buf_in);
        else begin hold = 1'b1; held = buf_in; end
      end
      @(posedge clk); #1;
    end
    start_row = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; ld_valid = 1'b0; ld_data = '0; start_row = 1'b0;
    flush = 1'b0; filter_size = '0; ready = 1'b1;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we); end
    checks++; if (buf_in !== '0) begin errors++; $display("FAIL reset_data got %h want 0", buf_in); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    checks++; if (staged_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", staged_count); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
  endtask

  task automatic test_basic_row(input int rmode, input string nm);
    stage_q.delete();
    for (int i = 1; i <= 4; i++) load_word(DW'(i));
    checks++; if (staged_count !== CW'(4)) begin errors++; $display("FAIL %s_staged got %0d want 4", nm, staged_count); end
    expect_row();
    pulse(1'b1, 1'b0, '0);
    checks++; if (busy !== 1'b1 || ld_ready !== 1'b0) begin errors++; $display("FAIL %s_busy got busy=%b ld_ready=%b want 1/0", nm, busy, ld_ready); end
    collect(20, rmode, (rmode == 1) ? 2 : -1);
    checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL %s_len got %0d want %0d", nm, got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL %s_word%0d got %h want %h", nm, i, got[i], exp_q[i]); end
    end
    checks++; if (first_we !== 0) begin errors++; $display("FAIL %s_latency got %0d want 0", nm, first_we); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s_done_cnt got %0d want 1", nm, done_cnt); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL %s_stable got %0d want 0", nm, stab_err); end
    if (rmode == 0) begin
      checks++; if (done_cycle !== 4) begin errors++; $display("FAIL %s_done_cycle got %0d want 4", nm, done_cycle); end
    end
    checks++; if (staged_count !== '0 || busy !== 1'b0) begin errors++; $display("FAIL %s_end got count=%0d busy=%b want 0/0", nm, staged_count, busy); end
    stage_q.delete();
  endtask

  task automatic test_flush();
    int sizes[3] = '{4, 1, 0};
    foreach (sizes[k]) begin
      expect_flush(sizes[k]);
      pulse(1'b0, 1'b1, FW'(sizes[k]));
      collect(12, 0, -1);
      checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL flush%0d_len got %0d want %0d", sizes[k], got.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got.size()) begin
        checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL flush%0d_word%0d got %h want %h", sizes[k], i, got[i], exp_q[i]); end
      end
      checks++; if (done_cnt !== 1 || done_cycle !== sizes[k]) begin errors++; $display("FAIL flush%0d_done got cnt=%0d cyc=%0d want 1/%0d", sizes[k], done_cnt, done_cycle, sizes[k]); end
    end
    pulse(1'b1, 1'b0, '0);
    collect(4, 0, -1);
    checks++; if (got.size() !== 0 || done_cycle !== 0) begin errors++; $display("FAIL empty_start got words=%0d done_cyc=%0d want 0/0", got.size(), done_cycle); end
  endtask

  task automatic test_overflow();
    logic exp_rdy;
    stage_q.delete();
    for (int i = 0; i < RD + 1; i++) begin
      exp_rdy = (stage_q.size() < RD);
      checks++; if (ld_ready !== exp_rdy) begin errors++; $display("FAIL ovf_ld_ready%0d got %b want %b", i, ld_ready, exp_rdy); end
      load_word(DW'($urandom));
    end
    checks++; if (staged_count !== CW'(RD)) begin errors++; $display("FAIL ovf_staged got %0d want %0d", staged_count, RD); end
    expect_row();
    pulse(1'b1, 1'b1, 5'd5);
    collect(2 * RD + 12, 0, -1);
    checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_len got %0d want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (done_cnt !== 1 || done_cycle !== RD) begin errors++; $display("FAIL ovf_done got cnt=%0d cyc=%0d want 1/%0d", done_cnt, done_cycle, RD); end
    stage_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] w2;
    int            stray;
    stage_q.delete();
    for (int i = 0; i < 4; i++) load_word(DW'($urandom));
    expect_row();
    w2 = exp_q[2];
    ready = 1'b1;
    pulse(1'b1, 1'b0, '0);
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (buf_in !== w2) begin errors++; $display("FAIL rmid_word2 got %h want %h", buf_in, w2); end
    #2 reset = 1'b0;
    #1;
    checks++; if (we !== 1'b0 || busy !== 1'b0 || staged_count !== '0) begin errors++; $display("FAIL rmid_clear got we=%b busy=%b count=%0d want 0/0/0", we, busy, staged_count); end
    @(posedge clk); #1 reset = 1'b1;
    stray = 0;
    repeat (3) begin @(posedge clk); #1; if (we !== 1'b0) stray++; end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rmid_stray got %0d want 0", stray); end
    stage_q.delete();
    for (int i = 0; i < 3; i++) load_word(DW'($urandom));
    expect_row();
    pulse(1'b1, 1'b0, '0);
    collect(10, 0, -1);
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL rmid_len got %0d want 3", got.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_word%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    stage_q.delete();
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        n = $urandom_range(1, RD);
        stage_q.delete();
        for (int i = 0; i < n; i++) load_word(DW'($urandom));
        expect_row();
        pulse(1'b1, 1'b0, '0);
      end else begin
        n = $urandom_range(1, 20);
        expect_flush(n);
        pulse(1'b0, 1'b1, FW'(n));
      end
      collect(4 * n + 8, 2, -1);
      checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_len got %0d want %0d", it, got.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got.size()) begin
        checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_word%0d got %h want %h", it, i, got[i], exp_q[i]); end
      end
      checks++; if (done_cnt !== 1 || stab_err !== 0) begin errors++; $display("FAIL rnd%0d_ctl got done=%0d stab=%0d want 1/0", it, done_cnt, stab_err); end
      checks++; if (staged_count !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_end got count=%0d busy=%b want 0/0", it, staged_count, busy); end
      stage_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic_row(0, "row");
    test_basic_row(1, "toggle");
    test_flush();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
